// File: rtl/bcd_timekeeper.sv
// bcd_timekeeper: time-of-day source for the VGA clock display.
// A prescaler divides px_clk down to a one-second tick. Six BCD digits hold
// HH:MM:SS in 24 h format. Single-cycle adjust pulses from the buttons nudge
// each field. A 4-bit colour offset advances whenever the minutes field changes.
// Every output comes straight from a register, so the render stage only ever
// sees settled and legal digit values.
module bcd_timekeeper #(
  parameter int TICK_DIV = 31_500_000
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       run,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hrs,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic [3:0] color_offset,
  output logic       sec_tick,
  output logic       day_wrap
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // BCD helpers
  // ---------------------------------------------------------------------------

  // Mod-60 increment of a two-digit BCD field; returns {tens, units}.
  function automatic logic [6:0] bcd60_inc(input logic [2:0] tens,
                                           input logic [3:0] units);
    logic [6:0] res;
    if (units == 4'd9) begin
      if (tens == 3'd5) begin
        res = 7'd0;
      end else begin
        res = {tens + 3'd1, 4'd0};
      end
    end else begin
      res = {tens, units + 4'd1};
    end
    return res;
  endfunction

  // Mod-24 increment of the BCD hours field; returns {tens, units}.
  function automatic logic [5:0] bcd24_inc(input logic [1:0] tens,
                                           input logic [3:0] units);
    logic [5:0] res;
    if ((tens == 2'd2) && (units == 4'd3)) begin
      res = 6'd0;
    end else if (units == 4'd9) begin
      res = {tens + 2'd1, 4'd0};
    end else begin
      res = {tens, units + 4'd1};
    end
    return res;
  endfunction

  // True when a minutes/seconds field sits at 59.
  function automatic logic bcd60_at_max(input logic [2:0] tens,
                                        input logic [3:0] units);
    return (tens == 3'd5) && (units == 4'd9);
  endfunction

  // True when the hours field sits at 23.
  function automatic logic bcd24_at_max(input logic [1:0] tens,
                                        input logic [3:0] units);
    return (tens == 2'd2) && (units == 4'd3);
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [3:0]       sec_u_q, sec_u_d;
  logic [2:0]       sec_d_q, sec_d_d;
  logic [3:0]       min_u_q, min_u_d;
  logic [2:0]       min_d_q, min_d_d;
  logic [3:0]       hrs_u_q, hrs_u_d;
  logic [1:0]       hrs_d_q, hrs_d_d;
  logic [3:0]       color_q, color_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;

  logic tick_s;
  logic sec_max_s;
  logic min_max_s;
  logic hrs_max_s;

  assign tick_s    = run && (cnt_q == CNT_MAX);
  assign sec_max_s = bcd60_at_max(sec_d_q, sec_u_q);
  assign min_max_s = bcd60_at_max(min_d_q, min_u_q);
  assign hrs_max_s = bcd24_at_max(hrs_d_q, hrs_u_q);

  // Prescaler next state: count while running, wrap at the top, hold when paused.
  always_comb begin
    cnt_d = cnt_q;
    if (run) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Time next state: the tick resolves the whole carry chain in one step.
  // Adjust pulses are applied only when no tick occurs, and each one stays
  // within its own field.
  always_comb begin
    sec_u_d    = sec_u_q;
    sec_d_d    = sec_d_q;
    min_u_d    = min_u_q;
    min_d_d    = min_d_q;
    hrs_u_d    = hrs_u_q;
    hrs_d_d    = hrs_d_q;
    color_d    = color_q;
    sec_tick_d = tick_s;
    day_wrap_d = 1'b0;

    if (tick_s) begin
      {sec_d_d, sec_u_d} = bcd60_inc(sec_d_q, sec_u_q);
      if (sec_max_s) begin
        {min_d_d, min_u_d} = bcd60_inc(min_d_q, min_u_q);
        color_d            = color_q + 4'd1;
        if (min_max_s) begin
          {hrs_d_d, hrs_u_d} = bcd24_inc(hrs_d_q, hrs_u_q);
          day_wrap_d         = hrs_max_s;
        end else begin
          day_wrap_d = 1'b0;
        end
      end else begin
        day_wrap_d = 1'b0;
      end
    end else begin
      if (adj_sec) begin
        {sec_d_d, sec_u_d} = bcd60_inc(sec_d_q, sec_u_q);
      end else begin
        {sec_d_d, sec_u_d} = {sec_d_q, sec_u_q};
      end
      if (adj_min) begin
        {min_d_d, min_u_d} = bcd60_inc(min_d_q, min_u_q);
        color_d            = color_q + 4'd1;
      end else begin
        {min_d_d, min_u_d} = {min_d_q, min_u_q};
      end
      if (adj_hrs) begin
        {hrs_d_d, hrs_u_d} = bcd24_inc(hrs_d_q, hrs_u_q);
      end else begin
        {hrs_d_d, hrs_u_d} = {hrs_d_q, hrs_u_q};
      end
    end
  end

  // State registers; the synchronous reset overrides ticks and adjust pulses.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      cnt_q      <= '0;
      sec_u_q    <= 4'd0;
      sec_d_q    <= 3'd0;
      min_u_q    <= 4'd0;
      min_d_q    <= 3'd0;
      hrs_u_q    <= 4'd0;
      hrs_d_q    <= 2'd0;
      color_q    <= 4'd0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sec_u_q    <= sec_u_d;
      sec_d_q    <= sec_d_d;
      min_u_q    <= min_u_d;
      min_d_q    <= min_d_d;
      hrs_u_q    <= hrs_u_d;
      hrs_d_q    <= hrs_d_d;
      color_q    <= color_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign sec_u        = sec_u_q;
  assign sec_d        = sec_d_q;
  assign min_u        = min_u_q;
  assign min_d        = min_d_q;
  assign hrs_u        = hrs_u_q;
  assign hrs_d        = hrs_d_q;
  assign color_offset = color_q;
  assign sec_tick     = sec_tick_q;
  assign day_wrap     = day_wrap_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Testbench for bcd_timekeeper, built with TICK_DIV=4.
// A seconds-of-day reference model is compared against the DUT every cycle.
// Directed tables and sequences cover the corner cases.
module tb_bcd_timekeeper;

  localparam int TD = 4;

  logic       px_clk = 1'b0;
  logic       reset, run, adj_sec, adj_min, adj_hrs;
  logic [3:0] sec_u, min_u, hrs_u, color_offset;
  logic [2:0] sec_d, min_d;
  logic [1:0] hrs_d;
  logic       sec_tick, day_wrap;

  int total = 0;
  int bad   = 0;

  // Reference model state: time as seconds of the day.
  int  m_t, m_p, m_color;
  bit  m_tick, m_wrap;
  bit  prev_tick, prev_wrap;

  bcd_timekeeper #(.TICK_DIV(TD)) dut (
    .px_clk(px_clk), .reset(reset), .run(run),
    .adj_sec(adj_sec), .adj_min(adj_min), .adj_hrs(adj_hrs),
    .sec_u(sec_u), .sec_d(sec_d), .min_u(min_u), .min_d(min_d),
    .hrs_u(hrs_u), .hrs_d(hrs_d), .color_offset(color_offset),
    .sec_tick(sec_tick), .day_wrap(day_wrap)
  );

  always #5 px_clk = ~px_clk;

  function automatic int dut_sec(); return int'(sec_d) * 10 + int'(sec_u); endfunction
  function automatic int dut_min(); return int'(min_d) * 10 + int'(min_u); endfunction
  function automatic int dut_hrs(); return int'(hrs_d) * 10 + int'(hrs_u); endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance the model by one clock, following the rules stated in seconds-of-day terms.
  task automatic model_update(input bit r, input bit ru, input bit as, input bit am, input bit ah);
    int s, m, h;
    bit tk;
    if (r) begin
      m_t = 0; m_p = 0; m_color = 0; m_tick = 0; m_wrap = 0;
    end else begin
      tk = ru && (m_p == TD - 1);
      if (ru) m_p = (m_p + 1) % TD;
      m_tick = tk;
      m_wrap = 0;
      if (tk) begin
        if (m_t % 60 == 59) m_color = (m_color + 1) % 16;
        m_t = (m_t + 1) % 86400;
        if (m_t == 0) m_wrap = 1;
      end else begin
        s = m_t % 60; m = (m_t / 60) % 60; h = m_t / 3600;
        if (as) s = (s + 1) % 60;
        if (am) begin m = (m + 1) % 60; m_color = (m_color + 1) % 16; end
        if (ah) h = (h + 1) % 24;
        m_t = h * 3600 + m * 60 + s;
      end
    end
  endtask

  // Compare the full DUT state with the model and check the output invariants.
  task automatic check_model();
    int exp_v, act_v;
    bit legal;
    exp_v = (m_t / 3600) * 10000 + ((m_t / 60) % 60) * 100 + (m_t % 60);
    exp_v = exp_v * 1000 + m_color * 10 + int'(m_tick) * 2 + int'(m_wrap);
    act_v = dut_hrs() * 10000 + dut_min() * 100 + dut_sec();
    act_v = act_v * 1000 + int'(color_offset) * 10 + int'(sec_tick) * 2 + int'(day_wrap);
    chk("model", act_v, exp_v);
    legal = (sec_u <= 4'd9) && (sec_d <= 3'd5) && (min_u <= 4'd9) && (min_d <= 3'd5) &&
            (hrs_u <= 4'd9) && (hrs_d <= 2'd2) && !(hrs_d == 2'd2 && hrs_u > 4'd3) &&
            !(sec_tick && prev_tick) && !(day_wrap && prev_wrap);
    chk("legal", int'(legal), 1);
    prev_tick = sec_tick;
    prev_wrap = day_wrap;
  endtask

  task automatic step(input bit r, input bit ru, input bit as, input bit am, input bit ah);
    reset = r; run = ru; adj_sec = as; adj_min = am; adj_hrs = ah;
    @(posedge px_clk); #1;
    model_update(r, ru, as, am, ah);
    check_model();
  endtask

  typedef struct {
    bit rst, ru, as, am, ah;
    int exp_sec;
    bit exp_tick;
    int exp_color;
  } vec_t;

  vec_t vecs[13];
  int   col0;

  initial begin
    reset = 1'b1; run = 1'b0; adj_sec = 1'b0; adj_min = 1'b0; adj_hrs = 1'b0;
    prev_tick = 0; prev_wrap = 0;

    // Reset (adj pulses ignored) followed by 12 running cycles.
    vecs[0]  = '{1, 1, 1, 1, 1, 0, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 0, 0, 0, 1, 1, 0};
    vecs[5]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    vecs[6]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 1, 0, 0};
    vecs[8]  = '{0, 1, 0, 0, 0, 2, 1, 0};
    vecs[9]  = '{0, 1, 0, 0, 0, 2, 0, 0};
    vecs[10] = '{0, 1, 0, 0, 0, 2, 0, 0};
    vecs[11] = '{0, 1, 0, 0, 0, 2, 0, 0};
    vecs[12] = '{0, 1, 0, 0, 0, 3, 1, 0};

    @(posedge px_clk); #1;
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].ru, vecs[i].as, vecs[i].am, vecs[i].ah);
      chk("tbl_sec", dut_sec(), vecs[i].exp_sec);
      chk("tbl_tick", int'(sec_tick), int'(vecs[i].exp_tick));
      chk("tbl_color", int'(color_offset), vecs[i].exp_color);
    end
    chk("tbl_hhmm", dut_hrs() * 100 + dut_min(), 0);

    // Preload 00:00:59, then one tick carries into minutes.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
    chk("pre59_sec", dut_sec(), 59);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("pre59_hold", dut_sec(), 59);
    step(0, 1, 0, 0, 0);
    chk("carry_min", dut_hrs() * 10000 + dut_min() * 100 + dut_sec(), 100);
    chk("carry_color", int'(color_offset), 1);

    // Preload 23:59:59, then one tick wraps the day.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 1, 0, 0);
    chk("pre_day", dut_hrs() * 10000 + dut_min() * 100 + dut_sec(), 235959);
    chk("pre_day_color", int'(color_offset), 11);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    chk("pre_wrap_flag", int'(day_wrap), 0);
    step(0, 1, 0, 0, 0);
    chk("wrap_time", dut_hrs() * 10000 + dut_min() * 100 + dut_sec(), 0);
    chk("wrap_flag", int'(day_wrap), 1);
    chk("wrap_color", int'(color_offset), 12);
    step(0, 0, 0, 0, 0);
    chk("wrap_flag_once", int'(day_wrap), 0);

    // adj_hrs at 23 goes to 00 without day_wrap.
    for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1);
    chk("hrs23", dut_hrs(), 23);
    step(0, 0, 0, 0, 1);
    chk("hrs_wrap", dut_hrs(), 0);
    chk("hrs_wrap_flag", int'(day_wrap), 0);

    // adj_min at 12:59:30 goes to 12:00:30 and advances the colour.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 1, 0, 0);
    col0 = int'(color_offset);
    step(0, 0, 0, 1, 0);
    chk("adjmin_wrap", dut_hrs() * 10000 + dut_min() * 100 + dut_sec(), 120030);
    chk("adjmin_color", int'(color_offset), (col0 + 1) % 16);

    // adj_sec at 00:00:59 goes to 00:00:00 without touching minutes.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 0, 0);
    chk("adjsec_wrap", dut_hrs() * 10000 + dut_min() * 100 + dut_sec(), 0);

    // A tick and adj_sec in the same cycle: the tick wins.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("tick_vs_adj", dut_sec(), 6);
    chk("tick_vs_adj_t", int'(sec_tick), 1);

    // Pause mid-count, then resume: the prescaler phase is kept.
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      chk("pause_tick", int'(sec_tick), 0);
    end
    chk("pause_sec", dut_sec(), 0);
    step(0, 1, 0, 0, 0);
    chk("resume_t1", int'(sec_tick), 0);
    step(0, 1, 0, 0, 0);
    chk("resume_t2", int'(sec_tick), 1);

    // Reset mid-count: the first tick comes exactly TD cycles after release.
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1);
    chk("rst_mid", dut_hrs() * 10000 + dut_min() * 100 + dut_sec() + int'(color_offset), 0);
    for (int i = 1; i <= TD; i++) begin
      step(0, 1, 0, 0, 0);
      chk("rst_tick_phase", int'(sec_tick), (i == TD) ? 1 : 0);
    end

    // Randomised run against the reference model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
- Time-of-day source for the VGA clock display: divides px_clk to a 1 Hz tick and keeps HH:MM:SS as six BCD digits (24 h format).
- Applies single-cycle adjust pulses from the button pulse generators.
- Maintains the 4-bit colour offset consumed by the digit renderer.
- Sits directly upstream of the display/render stage, which only reads its registered outputs.

Parameters:
- TICK_DIV, 31_500_000: px_clk cycles per second tick; prescaler counts 0..TICK_DIV-1. Minimum legal value 2.
- CNT_W, $clog2(TICK_DIV): prescaler width (derived, not overridden).

Ports:
- px_clk  in  1  pixel clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- run  in  1  1 = prescaler counts; 0 = prescaler holds value and no ticks are produced.
- adj_sec  in  1  one-cycle pulse: seconds +1.
- adj_min  in  1  one-cycle pulse: minutes +1.
- adj_hrs  in  1  one-cycle pulse: hours +1.
- sec_u  out  4  seconds units, 0-9.
- sec_d  out  3  seconds tens, 0-5.
- min_u  out  4  minutes units, 0-9.
- min_d  out  3  minutes tens, 0-5.
- hrs_u  out  4  hours units, 0-9 (0-3 when hrs_d=2).
- hrs_d  out  2  hours tens, 0-2.
- color_offset  out  4  increments on every minute change.
- sec_tick  out  1  one-cycle pulse, coincident with the seconds update.
- day_wrap  out  1  one-cycle pulse when time wraps 23:59:59 -> 00:00:00 via tick.

Behaviour:
- Reset (synchronous, active-high) has priority over everything.
  - All digits, color_offset, prescaler, sec_tick and day_wrap go to 0.
  - All adj pulses are ignored in the reset cycle.
- Prescaler:
  - When run=1, prescaler increments each cycle.
  - At TICK_DIV-1 it returns to 0 and asserts internal tick for that cycle.
  - When run=0 it holds; no tick.
- Tick update, registered (visible the cycle after the prescaler is at TICK_DIV-1, same cycle as sec_tick=1):
  - Full carry chain resolved in ONE cycle; no intermediate illegal digit values (e.g. sec_u=10) may ever appear on outputs.
  - sec 59 -> 00 carries to minutes.
  - min 59 -> 00 carries to hours.
  - hours 23 -> 00, with day_wrap=1 for that cycle.
- Adjust pulses (when no tick in that cycle):
  - adj_sec: seconds +1 mod 60; no carry into minutes.
  - adj_min: minutes +1 mod 60; no carry into hours.
  - adj_hrs: hours +1 mod 24 (23 -> 00); day_wrap NOT asserted.
  - Multiple adj pulses in the same cycle are all applied independently.
- Tick and adj pulse in the same cycle: tick update wins; all adj pulses in that cycle are dropped.
- Adjust pulses do not touch the prescaler; seconds phase is preserved.
- color_offset:
  - +1 (mod 16, 15 -> 0) whenever the minutes field changes, whether by tick carry or by adj_min.
  - At most +1 per cycle.
- Output invariants, every cycle: all digit values legal BCD within the ranges above; hrs_d=2 implies hrs_u<=3.
- sec_tick and day_wrap are never asserted for more than one consecutive cycle (TICK_DIV>=2).
- Reset mid-count: the next tick occurs exactly TICK_DIV cycles after reset deasserts, given run=1.

Test Plan (TICK_DIV=4 unless noted):
- Reset, run=1, 12 cycles -> sec_tick every 4th cycle; sec_u=3 after 3rd tick; all other digits 0; color_offset 0.
- Preload 00:00:59 via 59 adj_sec pulses, then one tick -> 00:01:00; color_offset 0->1; no illegal intermediate values.
- Preload 23:59:59 (23 adj_hrs, 59 adj_min, 59 adj_sec), then tick -> 00:00:00; day_wrap=1 for exactly one cycle; color_offset +1.
- adj_hrs at 23:xx:xx -> hours 00, day_wrap=0. adj_min at 12:59:30 -> 12:00:30, color_offset +1. adj_sec at 00:00:59 -> 00:00:00, minutes unchanged.
- adj_sec asserted in the same cycle as tick at 00:00:05 -> 00:00:06 (not 07).
- run=0 for 10 cycles mid-count -> no sec_tick, digits frozen, prescaler holds. Reset asserted mid-count -> all outputs 0 next cycle; first tick exactly 4 cycles after release.
